// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage in front of the CPU controller FSM.
// Holds the program counter, reads one 16-bit instruction per request from
// program memory, latches it into the instruction register, and hands it to
// the controller with a start strobe, then waits for the controller to
// finish before fetching the next one.
module instr_fetch #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_valid,
  output logic [15:0]       instruction,
  output logic              s,
  input  logic              w,
  output logic              halted,
  output logic [15:0]       retired,
  output logic [2:0]        fetch_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    REQ      = 3'b001,
    WAIT_MEM = 3'b010,
    START    = 3'b011,
    BUSY     = 3'b100,
    HALT     = 3'b101
  } state_t;

  // Top three opcode bits of a HALT instruction
  localparam logic [2:0] HALT_OPCODE = 3'b111;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus_one;
  logic              is_halt;

  // PC increment wraps naturally at the address width
  assign pc_plus_one = pc + ADDR_W'(1);
  assign is_halt     = (mem_rdata[15:13] == HALT_OPCODE);

  // Memory port: the address always follows the PC, the read is a single-cycle pulse in REQ
  assign mem_addr = pc;
  assign mem_rd   = (state == REQ);

  // The start strobe is only offered while the controller sits in its wait state,
  // so the controller consumes it on exactly one edge
  assign s = (state == START) && w;

  assign halted      = (state == HALT);
  assign fetch_state = state;

  // Fetch sequencer: PC, instruction register, retired counter and state all advance together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= 16'h0000;
      retired     <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (pc_load) begin
            pc <= pc_in;
          end else if (run) begin
            state <= REQ;
          end
        end

        REQ: begin
          state <= WAIT_MEM;
        end

        WAIT_MEM: begin
          if (mem_valid) begin
            instruction <= mem_rdata;
            pc          <= pc_plus_one;
            state       <= is_halt ? HALT : START;
          end
        end

        START: begin
          if (w) begin
            state <= BUSY;
          end
        end

        BUSY: begin
          // The controller drops w on the edge it accepts s, so w high here means it has finished
          if (w) begin
            retired <= retired + 16'd1;
            state   <= run ? REQ : IDLE;
          end
        end

        HALT: begin
          if (pc_load) begin
            pc    <= pc_in;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
